// File: rtl/trng_collector.sv
// TRNG entropy collector: synchronised ring-oscillator inputs, XOR combine, optional
// von Neumann debias (define TRNG_VN_DEBIAS_EN), word packing, repetition-count health test.
module trng_collector #(
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned WIDTH      = 8,
  parameter int unsigned SAMPLE_DIV = 1,
  parameter int unsigned RCT_LIMIT  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              en,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic [NUM_CH-1:0] raw_in,
  input  logic              rd_ready,
  output logic              rd_valid,
  output logic [WIDTH-1:0]  rd_data,
  output logic              overrun,
  output logic              health_fail
);

  localparam int unsigned DIV_W = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int unsigned CNT_W = $clog2(WIDTH + 1);
  localparam int unsigned RUN_W = 8;
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SAMPLE_DIV - 1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);
  localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(RCT_LIMIT);

  logic [NUM_CH-1:0] sync1;
  logic [NUM_CH-1:0] sync2;
  logic [DIV_W-1:0]  div_cnt;
  logic [WIDTH-1:0]  acc;
  logic [CNT_W-1:0]  count;
  logic [RUN_W-1:0]  run_len;
  logic              last_bit;

  logic              strobe;
  logic              raw_valid;
  logic              raw_bit;
  logic              deb_valid;
  logic              deb_bit;
  logic              acc_valid;
  logic              full;
  logic              xfer_ok;
  logic [RUN_W-1:0]  run_next;

  // Two-flop synchroniser; runs regardless of en so samples are settled when collection starts.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_in;
      sync2 <= sync1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n || !en) begin
      div_cnt <= '0;
    end else if (strobe) begin
      div_cnt <= '0;
    end else begin
      div_cnt <= div_cnt + DIV_W'(1);
    end
  end

  always_comb begin
    strobe    = en && (div_cnt == DIV_LAST);
    raw_valid = strobe && (|ch_mask);
    raw_bit   = ^(sync2 & ch_mask);
  end

`ifdef TRNG_VN_DEBIAS_EN
  logic pair_full;
  logic pair_bit;

  // First bit of a pair is parked; a differing second bit releases the first one.
  always_ff @(posedge clk) begin
    if (rst_n || !en) begin
      pair_full <= 1'b0;
      pair_bit  <= 1'b0;
    end else if (raw_valid) begin
      if (!pair_full) begin
        pair_full <= 1'b1;
        pair_bit  <= raw_bit;
      end else begin
        pair_full <= 1'b0;
      end
    end
  end

  always_comb begin
    deb_valid = raw_valid && pair_full && (pair_bit != raw_bit);
    deb_bit   = pair_bit;
  end
`else
  always_comb begin
    deb_valid = raw_valid;
    deb_bit   = raw_bit;
  end
`endif

  always_comb begin
    acc_valid = deb_valid && !health_fail;
    full      = (count == CNT_FULL);
    xfer_ok   = !rd_valid || rd_ready;
    if ((run_len != '0) && (deb_bit == last_bit)) begin
      run_next = (run_len == RUN_MAX) ? RUN_MAX : run_len + RUN_W'(1);
    end else begin
      run_next = RUN_W'(1);
    end
  end

  // Word packing, output handshake and health tracking.
  always_ff @(posedge clk) begin
    if (rst_n) begin
      rd_valid    <= 1'b0;
      rd_data     <= '0;
      overrun     <= 1'b0;
      health_fail <= 1'b0;
      acc         <= '0;
      count       <= '0;
      run_len     <= '0;
      last_bit    <= 1'b0;
    end else begin
      if (rd_valid && rd_ready) begin
        rd_valid <= 1'b0;
      end
      if (!en) begin
        acc         <= '0;
        count       <= '0;
        run_len     <= '0;
        last_bit    <= 1'b0;
        health_fail <= 1'b0;
      end else begin
        if (full) begin
          if (xfer_ok) begin
            rd_data  <= acc;
            rd_valid <= 1'b1;
          end else begin
            overrun <= 1'b1;
          end
          // A bit landing on the hand-off cycle starts the next word.
          if (acc_valid) begin
            acc   <= WIDTH'(deb_bit);
            count <= CNT_W'(1);
          end else begin
            count <= '0;
          end
        end else if (acc_valid) begin
          acc   <= {acc[WIDTH-2:0], deb_bit};
          count <= count + CNT_W'(1);
        end
        if (acc_valid) begin
          last_bit <= deb_bit;
          run_len  <= run_next;
          if (run_next == RUN_MAX) begin
            health_fail <= 1'b1;
          end
        end
      end
    end
  end

endmodule

// File: tb/tb_trng_collector.sv
// Directed bench for trng_collector: vector table for word assembly plus hand-written
// sequences for overrun, health test, mid-operation reset and (when defined) von Neumann debias.
module tb_trng_collector;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic [3:0] ch_mask;
  logic [3:0] raw_in;
  logic       rd_ready;
  logic       rd_valid;
  logic [7:0] rd_data;
  logic       overrun;
  logic       health_fail;

  int checks = 0;
  int errors = 0;

  trng_collector #(
    .NUM_CH(4), .WIDTH(8), .SAMPLE_DIV(4), .RCT_LIMIT(16)
  ) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .ch_mask(ch_mask), .raw_in(raw_in),
    .rd_ready(rd_ready), .rd_valid(rd_valid), .rd_data(rd_data),
    .overrun(overrun), .health_fail(health_fail)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  mask;
    logic [31:0] smp;   // eight 4-bit samples, first sample in the top nibble
    logic [7:0]  word;
    string       name;
  } vec_t;

  vec_t vecs [5];

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
    end
  endtask

  // One sample per SAMPLE_DIV (4) clocks, aligned to the divider started by en/reset.
  task automatic feed(input logic [3:0] v);
    raw_in = v;
    repeat (4) tick;
  endtask

  task automatic feed_word(input logic [31:0] s);
    for (int i = 0; i < 8; i++) feed(s[31-4*i -: 4]);
  endtask

  task automatic wait_word(input string name, input logic [7:0] exp);
    int n;
    n = 0;
    while (!rd_valid && n < 12) begin
      tick;
      n++;
    end
    if (!rd_valid) chk({name, "_timeout"}, 32'(rd_valid), 32'd1);
    else           chk(name, 32'(rd_data), 32'(exp));
  endtask

  task automatic restart;
    en = 1'b0;
    tick;
    en = 1'b1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [3:0] pat;

    vecs[0] = '{mask: 4'b0001, smp: 32'h1011_0010, word: 8'hB2, name: "vec_m1_B2"};
    vecs[1] = '{mask: 4'b0011, smp: 32'h3120_3120, word: 8'h66, name: "vec_m3_66"};
    vecs[2] = '{mask: 4'b1000, smp: 32'h8F9E_7035, word: 8'hF0, name: "vec_m8_F0"};
    vecs[3] = '{mask: 4'b1111, smp: 32'h137F_EC80, word: 8'hAA, name: "vec_mF_AA"};
    vecs[4] = '{mask: 4'b0101, smp: 32'h5410_FA63, word: 8'h63, name: "vec_m5_63"};

    rst_n = 1'b1; en = 1'b0; ch_mask = '0; raw_in = '0; rd_ready = 1'b0;
    repeat (2) tick;
    chk("rst_valid",  32'(rd_valid), 32'd0);
    chk("rst_data",   32'(rd_data), 32'd0);
    chk("rst_ovr",    32'(overrun), 32'd0);
    chk("rst_health", 32'(health_fail), 32'd0);
    rst_n = 1'b0;
    tick;

`ifdef TRNG_VN_DEBIAS_EN
    // Pairs 10,01,11,10,00,10,01,01,11,10,01 -> 1,0,-,1,-,1... yields 1,0,1,1,0,0,1,0.
    rd_ready = 1'b1;
    ch_mask  = 4'b0001;
    restart;
    pat = '0;
    for (int i = 0; i < 22; i++) begin
      logic [21:0] seq;
      seq = 22'b10_01_11_10_00_10_01_01_11_10_01;
      pat = {3'b000, seq[21-i]};
      feed(pat);
    end
    wait_word("vn_word", 8'hB2);
`else
    rd_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      ch_mask = vecs[v].mask;
      restart;
      feed_word(vecs[v].smp);
      wait_word(vecs[v].name, vecs[v].word);
    end

    // ch_mask = 0 produces no bits; the following word holds only masked-in samples.
    ch_mask = 4'b0000;
    restart;
    seen = 0;
    for (int i = 0; i < 48; i++) begin
      if (i % 4 == 0) raw_in = (i % 8 == 0) ? 4'hF : 4'h0;
      tick;
      if (rd_valid) seen = 1;
    end
    chk("mask0_no_word", 32'(seen), 32'd0);
    ch_mask = 4'b0001;
    feed_word(32'h1011_0010);
    wait_word("mask0_then_word", 8'hB2);

    // Consumer stalled for three words: first held, two dropped, overrun sticky.
    tick;
    rd_ready = 1'b0;
    restart;
    for (int w = 0; w < 3; w++) begin
      for (int i = 0; i < 8; i++) begin
        feed(vecs[0].smp[31-4*i -: 4]);
        if (w == 1 && i == 0) begin
          chk("ovr_w1_valid", 32'(rd_valid), 32'd1);
          chk("ovr_w1_data",  32'(rd_data), 32'hB2);
          chk("ovr_w1_flag",  32'(overrun), 32'd0);
        end
        if (w == 2 && i == 0) chk("ovr_w2_flag", 32'(overrun), 32'd1);
      end
    end
    repeat (2) tick;
    chk("ovr_hold_valid", 32'(rd_valid), 32'd1);
    chk("ovr_hold_data",  32'(rd_data), 32'hB2);
    chk("ovr_hold_flag",  32'(overrun), 32'd1);
    rd_ready = 1'b1;
    tick;
    chk("ovr_consumed", 32'(rd_valid), 32'd0);
    en = 1'b0;
    tick;
    chk("ovr_sticky_en0", 32'(overrun), 32'd1);
    chk("ovr_data_kept",  32'(rd_data), 32'hB2);

    // Constant ones: 16th accepted bit trips the repetition-count test.
    ch_mask = 4'b0001;
    raw_in  = 4'h1;
    repeat (3) tick;
    en = 1'b1;
    repeat (63) tick;
    chk("rct_before_limit", 32'(health_fail), 32'd0);
    tick;
    chk("rct_at_limit", 32'(health_fail), 32'd1);
    chk("rct_word1",    32'(rd_data), 32'hFF);
    repeat (3) tick;
    seen = 0;
    for (int i = 0; i < 60; i++) begin
      tick;
      if (rd_valid) seen = 1;
    end
    chk("rct_no_words", 32'(seen), 32'd0);
    en = 1'b0;
    tick;
    chk("rct_cleared_en0", 32'(health_fail), 32'd0);

    // Reset after 5 bits: partial word abandoned, next word from fresh bits only.
    ch_mask = 4'b0001;
    restart;
    for (int i = 0; i < 5; i++) feed(4'h1);
    rst_n = 1'b1;
    tick;
    chk("mid_rst_valid",  32'(rd_valid), 32'd0);
    chk("mid_rst_data",   32'(rd_data), 32'd0);
    chk("mid_rst_ovr",    32'(overrun), 32'd0);
    chk("mid_rst_health", 32'(health_fail), 32'd0);
    rst_n = 1'b0;
    feed_word(32'h0110_1001);
    wait_word("mid_rst_word", 8'h69);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/trng_collector.md
TRNG_COLLECTOR -- requirements
Module: trng_collector

Interface
REQ-001 SHALL have parameter NUM_CH, default 4: number of ring-oscillator raw inputs, range 1..16.
REQ-002 SHALL have parameter WIDTH, default 8: output word width, range 2..32.
REQ-003 SHALL have parameter SAMPLE_DIV, default 1: clocks per sample strobe, range 1..256.
REQ-004 SHALL have parameter RCT_LIMIT, default 16: repetition-count failure threshold, range 2..255.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-006 SHALL have port rst_n, input, 1 bit: synchronous reset, active-high (asserted = 1) despite the suffix.
REQ-007 SHALL have port en, input, 1 bit: collection enable.
REQ-008 SHALL have port ch_mask, input, NUM_CH bits: selects the channels that are XOR-combined.
REQ-009 SHALL have port raw_in, input, NUM_CH bits: asynchronous ring-oscillator outputs.
REQ-010 SHALL have port rd_ready, input, 1 bit: consumer ready.
REQ-011 SHALL have port rd_valid, output, 1 bit: rd_data holds an unread word.
REQ-012 SHALL have port rd_data, output, WIDTH bits: random word.
REQ-013 SHALL have port overrun, output, 1 bit: sticky flag, a completed word was dropped.
REQ-014 SHALL have port health_fail, output, 1 bit: sticky repetition-count failure.

Function
REQ-015 SHALL pass each raw_in bit through a 2-flop synchroniser before any use.
REQ-016 SHALL run a divider counter 0..SAMPLE_DIV-1 while en=1 and strobe when count = SAMPLE_DIV-1; counter held at 0 while en=0.
REQ-017 SHALL form the raw bit on each strobe as the XOR of the synchronised bits selected by ch_mask; no raw bit is produced when ch_mask = 0.
REQ-018 SHALL pass each raw bit through the debias stage (REQ-031/REQ-032); bits leaving it are "accepted bits".
REQ-019 SHALL shift each accepted bit into an accumulator at the LSB (shift left) and increment a bit count.
REQ-020 SHALL, on the edge after the count reaches WIDTH, move the accumulator to rd_data, set rd_valid and clear the count, provided rd_valid=0 or rd_ready=1 in that cycle.
REQ-021 SHALL, if an accepted bit arrives in the same cycle as a transfer, store it as bit 0 of the next word with count = 1.
REQ-022 SHALL, when the count is WIDTH and the output register is blocked, discard the full accumulator, clear the count and set overrun.
REQ-023 SHALL hold rd_data and rd_valid stable while rd_valid=1 and rd_ready=0; a word is consumed on a cycle where rd_valid=1 and rd_ready=1.
REQ-024 SHALL track consecutive identical accepted bits; health_fail sets when the run length reaches RCT_LIMIT.
REQ-025 SHALL, while health_fail=1, accept no new bits into the accumulator; the current rd_data is still readable.
REQ-026 SHALL, when en=0, clear the divider, accumulator, count, debias state, run counter and health_fail; rd_data, rd_valid and overrun are retained.

Reset
REQ-027 SHALL, with rst_n=1 at a clock edge, drive rd_valid=0, rd_data=0, overrun=0 and health_fail=0.
REQ-028 SHALL, with rst_n=1 at a clock edge, clear the synchronisers, divider, accumulator, count, debias state and run counter.
REQ-029 SHALL abandon any partial word on reset mid-operation; the first word after reset contains only bits sampled after reset.
REQ-030 SHALL give reset priority over en and rd_ready.

Configuration
REQ-031 SHALL, with macro TRNG_VN_DEBIAS_EN defined, apply von Neumann debiasing: pair raw bits (a,b); emit a when a != b; discard 00/11 pairs; the pair register clears on en=0 or reset.
REQ-032 SHALL, without TRNG_VN_DEBIAS_EN, treat every raw bit as an accepted bit on its strobe cycle.

Verification
REQ-033 SHALL cover: WIDTH=8, ch_mask=0001, no VN, raw_in[0] = 1,0,1,1,0,0,1,0 per strobe, rd_ready=1 -> rd_valid pulses with rd_data=8'hB2.
REQ-034 SHALL cover: ch_mask=0011, raw_in[1:0] = 11,01,10,00 repeated twice -> rd_data=8'h66.
REQ-035 SHALL cover: TRNG_VN_DEBIAS_EN, raw pairs 10,01,11,00,10,... -> emitted bits 1,0,1,...; 11/00 pairs produce no bit.
REQ-036 SHALL cover: rd_ready=0 for 3 word times -> first word held stable, second and third dropped, overrun=1 until reset.
REQ-037 SHALL cover: constant raw_in=1, RCT_LIMIT=16 -> health_fail=1 at the 16th accepted bit, no further words; en low for 1 cycle clears it.
REQ-038 SHALL cover: rst_n=1 asserted after 5 bits accumulated -> all outputs 0; the next word is built from 8 fresh bits.
